// File: rtl/resp_pkg.sv
// resp_pkg: shared types and defaults for the response checker.
//   state_e   : session FSM states (IDLE, RUN, DONE)
//   VEC_W     : width of the applied stimulus vector {a,b,c,d,e,f,g}
//   SIG_W_DEF : default MISR signature width
//   POLY_DEF  : default MISR feedback polynomial
package resp_pkg;

   localparam int VEC_W = 7;
   localparam int SIG_W_DEF = 16;
   localparam logic [15:0] POLY_DEF = 16'h1021;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/resp_misr.sv
// resp_misr: multiple-input signature register.
//   clk, rst_n : clock, async active-low reset (signature resets to all-ones)
//   init       : load all-ones (wins over en)
//   en         : compact din into the signature this cycle
//   din        : 8-bit beat data, placed in the signature LSBs
//   sig        : current signature
module resp_misr #(
   parameter int SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             en,
   input  logic [7:0]       din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_next;

   always_comb begin
      sig_next = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ {{(SIG_W-8){1'b0}}, din};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '1;
      end else if (init) begin
         sig_q <= '1;
      end else if (en) begin
         sig_q <= sig_next;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/resp_checker.sv
// resp_checker: receiving end of the 7-input stimulus stream. Compacts
// accepted beats {vec, y} into a MISR signature and counts beats and ones.
//   clk, rst_n          : clock, async active-low reset
//   start, end_req      : one-cycle session open/restart and close pulses
//   vec_valid/vec_ready : beat handshake; vec (bit6=a .. bit0=g) and y
//   busy, done          : session open / session closed with stable results
//   sig                 : MISR signature
//   vec_cnt, ones_cnt   : saturating beat and y=1 counters
//   conflict            : sticky, same vec seen with differing y
// Optional feature macro: RESP_TABLE_EN enables the per-vector seen/y tables
// that drive conflict; without it conflict is tied low.
//
// state | meaning
// IDLE  | after reset, no session yet; outputs hold
// RUN   | session open, beats accepted every cycle
// DONE  | session closed, results held until start
module resp_checker
   import resp_pkg::*;
#(
   parameter int SIG_W = SIG_W_DEF,
   parameter logic [SIG_W-1:0] POLY = SIG_W'(POLY_DEF),
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             end_req,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [VEC_W-1:0] vec,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] sig,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] ones_cnt,
   output logic             conflict
);

   state_e state_q;
   state_e state_d;
   logic clr;
   logic accept;
   logic [CNT_W-1:0] vec_cnt_q;
   logic [CNT_W-1:0] ones_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // start wins over end_req in every state; a restart stays in RUN.
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               clr     = 1'b1;
            end
         end
         RUN: begin
            if (start) begin
               clr = 1'b1;
            end else if (end_req) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign vec_ready = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

   // A beat handshaked together with a restart is dropped.
   assign accept = vec_valid && vec_ready && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt_q  <= '0;
         ones_cnt_q <= '0;
      end else if (clr) begin
         vec_cnt_q  <= '0;
         ones_cnt_q <= '0;
      end else if (accept) begin
         if (vec_cnt_q != '1) begin
            vec_cnt_q <= vec_cnt_q + CNT_W'(1);
         end
         if (y && (ones_cnt_q != '1)) begin
            ones_cnt_q <= ones_cnt_q + CNT_W'(1);
         end
      end
   end

   assign vec_cnt  = vec_cnt_q;
   assign ones_cnt = ones_cnt_q;

   resp_misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (clr),
      .en    (accept),
      .din   ({vec, y}),
      .sig   (sig)
   );

`ifdef RESP_TABLE_EN
   logic [(1<<VEC_W)-1:0] seen_q;
   logic [(1<<VEC_W)-1:0] ytab_q;
   logic conflict_q;

   // Only the first occurrence of a vector records y; later beats compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q     <= '0;
         ytab_q     <= '0;
         conflict_q <= 1'b0;
      end else if (clr) begin
         seen_q     <= '0;
         ytab_q     <= '0;
         conflict_q <= 1'b0;
      end else if (accept) begin
         if (seen_q[vec]) begin
            if (ytab_q[vec] != y) begin
               conflict_q <= 1'b1;
            end
         end else begin
            seen_q[vec] <= 1'b1;
            ytab_q[vec] <= y;
         end
      end
   end

   assign conflict = conflict_q;
`else
   assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_resp_checker.sv
module tb_resp_checker;

`ifdef RESP_TABLE_EN
   localparam bit TABLE_EN = 1'b1;
`else
   localparam bit TABLE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        end_req;
   logic        vec_valid;
   logic        vec_ready;
   logic [6:0]  vec;
   logic        y;
   logic        busy;
   logic        done;
   logic [15:0] sig;
   logic [7:0]  vec_cnt;
   logic [7:0]  ones_cnt;
   logic        conflict;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   resp_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .end_req   (end_req),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec       (vec),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .sig       (sig),
      .vec_cnt   (vec_cnt),
      .ones_cnt  (ones_cnt),
      .conflict  (conflict)
   );

   typedef struct {
      logic [6:0] v;
      logic       yy;
   } beat_t;

   typedef struct {
      logic [15:0] sig;
      logic [7:0]  vc;
      logic [7:0]  oc;
      logic        conf;
   } exp_t;

   exp_t exp_q[$];

   // reference model
   logic [15:0] m_sig;
   logic [7:0]  m_vc;
   logic [7:0]  m_oc;
   logic        m_conf;
   logic        m_seen[128];
   logic        m_y[128];

   function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [7:0] d);
      logic [15:0] r;
      r = {s[14:0], 1'b0} ^ {8'h00, d};
      if (s[15]) r = r ^ 16'h1021;
      return r;
   endfunction

   task automatic model_clear();
      m_sig  = 16'hFFFF;
      m_vc   = 8'd0;
      m_oc   = 8'd0;
      m_conf = 1'b0;
      for (int k = 0; k < 128; k++) begin
         m_seen[k] = 1'b0;
         m_y[k]    = 1'b0;
      end
   endtask

   task automatic model_beat(input logic [6:0] v, input logic yy);
      exp_t e;
      m_sig = misr_next(m_sig, {v, yy});
      if (m_vc != 8'hFF) m_vc = m_vc + 8'd1;
      if (yy && m_oc != 8'hFF) m_oc = m_oc + 8'd1;
      if (TABLE_EN) begin
         if (m_seen[v]) begin
            if (m_y[v] != yy) m_conf = 1'b1;
         end else begin
            m_seen[v] = 1'b1;
            m_y[v]    = yy;
         end
      end
      e.sig = m_sig; e.vc = m_vc; e.oc = m_oc; e.conf = m_conf;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic check_model(input string name);
      check({name, ".sig"}, 32'(sig), 32'(m_sig));
      check({name, ".vec_cnt"}, 32'(vec_cnt), 32'(m_vc));
      check({name, ".ones_cnt"}, 32'(ones_cnt), 32'(m_oc));
      check({name, ".conflict"}, 32'(conflict), 32'(m_conf));
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got sig %0h expected an entry", name, sig);
      end else begin
         e = exp_q.pop_front();
         if (sig !== e.sig || vec_cnt !== e.vc || ones_cnt !== e.oc || conflict !== e.conf) begin
            errors++;
            $display("FAIL %s: got sig=%0h vc=%0d oc=%0d conf=%0b expected sig=%0h vc=%0d oc=%0d conf=%0b",
                     name, sig, vec_cnt, ones_cnt, conflict, e.sig, e.vc, e.oc, e.conf);
         end
      end
   endtask

   task automatic check_reset_vals(input string name);
      check({name, ".vec_ready"}, 32'(vec_ready), 0);
      check({name, ".busy"}, 32'(busy), 0);
      check({name, ".done"}, 32'(done), 0);
      check({name, ".sig"}, 32'(sig), 32'h0000FFFF);
      check({name, ".vec_cnt"}, 32'(vec_cnt), 0);
      check({name, ".ones_cnt"}, 32'(ones_cnt), 0);
      check({name, ".conflict"}, 32'(conflict), 0);
   endtask

   // Called at a negedge; drives the start pulse and returns at the next negedge.
   task automatic do_start();
      start = 1'b1;
      model_clear();
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives one beat at the current negedge and compares at the next one.
   task automatic send(input logic [6:0] v, input logic yy, input string name);
      vec_valid = 1'b1;
      vec       = v;
      y         = yy;
      model_beat(v, yy);
      @(negedge clk);
      pop_check(name);
   endtask

   beat_t tbl[10];

   initial begin
      tbl[0] = '{7'h00, 1'b0};
      tbl[1] = '{7'h7F, 1'b1};
      tbl[2] = '{7'h55, 1'b0};
      tbl[3] = '{7'h2A, 1'b1};
      tbl[4] = '{7'h01, 1'b1};
      tbl[5] = '{7'h40, 1'b0};
      tbl[6] = '{7'h33, 1'b1};
      tbl[7] = '{7'h0F, 1'b0};
      tbl[8] = '{7'h70, 1'b1};
      tbl[9] = '{7'h18, 1'b0};

      rst_n = 1'b0; start = 1'b0; end_req = 1'b0;
      vec_valid = 1'b0; vec = '0; y = 1'b0;
      model_clear();
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_start();
      check("start.busy", 32'(busy), 1);
      check("start.vec_ready", 32'(vec_ready), 1);
      check("start.sig", 32'(sig), 32'h0000FFFF);
      check("start.vec_cnt", 32'(vec_cnt), 0);
      check("start.done", 32'(done), 0);

      send(7'h00, 1'b0, "beat00");
      vec_valid = 1'b0;
      check("beat00.sig_const", 32'(sig), 32'h0000EFDF);
      check("beat00.vec_cnt", 32'(vec_cnt), 1);
      check("beat00.ones_cnt", 32'(ones_cnt), 0);

      do_start();
      send(7'h03, 1'b1, "beat03");
      vec_valid = 1'b0;
      check("beat03.sig_const", 32'(sig), 32'h0000EFD8);
      check("beat03.ones_cnt", 32'(ones_cnt), 1);

      // back-to-back table beats
      do_start();
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].v, tbl[i].yy, $sformatf("tbl[%0d]", i));
      end
      vec_valid = 1'b0;
      @(negedge clk);
      check_model("tbl.hold");

      // end_req with a beat in the same cycle
      vec_valid = 1'b1; vec = 7'h2C; y = 1'b1; end_req = 1'b1;
      model_beat(7'h2C, 1'b1);
      @(negedge clk);
      end_req = 1'b0;
      pop_check("end_beat");
      check("end_beat.done", 32'(done), 1);
      check("end_beat.busy", 32'(busy), 0);
      check("end_beat.vec_ready", 32'(vec_ready), 0);
      vec = 7'h11; y = 1'b1;
      repeat (3) @(negedge clk);
      vec_valid = 1'b0;
      check_model("done.ignore");
      check("done.held", 32'(done), 1);

      // start with a beat in the same cycle: beat discarded
      do_start();
      send(7'h21, 1'b1, "pre_restart0");
      send(7'h22, 1'b0, "pre_restart1");
      vec = 7'h23; y = 1'b1;
      do_start();
      vec_valid = 1'b0;
      check("restart.sig", 32'(sig), 32'h0000FFFF);
      check("restart.vec_cnt", 32'(vec_cnt), 0);
      check("restart.ones_cnt", 32'(ones_cnt), 0);
      check("restart.busy", 32'(busy), 1);

      // conflict detection
      send(7'h18, 1'b0, "conf0");
      send(7'h18, 1'b1, "conf1");
      vec_valid = 1'b0;
      check("conf.flag", 32'(conflict), 32'(TABLE_EN));
      repeat (2) @(negedge clk);
      check("conf.hold", 32'(conflict), 32'(TABLE_EN));
      send(7'h05, 1'b0, "conf2");
      vec_valid = 1'b0;
      do_start();
      check("conf.cleared", 32'(conflict), 0);
      send(7'h18, 1'b0, "same0");
      send(7'h18, 1'b0, "same1");
      vec_valid = 1'b0;
      check("same.noconf", 32'(conflict), 0);

      // saturation
      do_start();
      for (int i = 0; i < 300; i++) begin
         send(7'(i), 1'b1, $sformatf("sat[%0d]", i));
      end
      vec_valid = 1'b0;
      check("sat.vec_cnt", 32'(vec_cnt), 255);
      check("sat.ones_cnt", 32'(ones_cnt), 255);
      end_req = 1'b1;
      @(negedge clk);
      end_req = 1'b0;
      check("sat.done", 32'(done), 1);
      check("sat.vec_ready", 32'(vec_ready), 0);
      vec_valid = 1'b1; vec = 7'h44; y = 1'b0;
      repeat (3) @(negedge clk);
      vec_valid = 1'b0;
      check_model("sat.ignore");

      // end_req outside RUN ignored
      end_req = 1'b1;
      @(negedge clk);
      end_req = 1'b0;
      check("done_endreq.done", 32'(done), 1);

      // asynchronous reset mid-session
      do_start();
      for (int i = 0; i < 5; i++) begin
         send(7'(i * 9), 1'(i), $sformatf("pre_rst[%0d]", i));
      end
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      @(negedge clk);
      vec_valid = 1'b0;
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      check_reset_vals("post_rst");
      do_start();
      check("resume.busy", 32'(busy), 1);
      send(7'h00, 1'b0, "resume_beat");
      vec_valid = 1'b0;
      check("resume.sig_const", 32'(sig), 32'h0000EFDF);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/resp_checker.md
# resp_checker

Sequential response checker for the lab combinational circuits: the receiving end of the 7-input stimulus stream. Each accepted beat carries an applied vector {a,b,c,d,e,f,g} and the circuit's output y. The block compacts the beats into a MISR signature and counts vectors and ones, so a session can be checked against one golden value instead of a monitor log. It sits between the stimulus source and the bench/scoreboard.

## Interface
- SIG_W, 16: signature width (≥ 9).
- POLY, 16'h1021: MISR feedback polynomial (SIG_W bits).
- CNT_W, 8: width of vector and ones counters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: open/restart session.
- end_req  in  1  one-cycle pulse: close session.
- vec_valid  in  1  beat valid.
- vec_ready  out  1  beat ready.
- vec  in  7  applied vector, bit6=a … bit0=g.
- y  in  1  circuit output for vec.
- busy  out  1  session open.
- done  out  1  session closed, results stable.
- sig  out  SIG_W  MISR signature.
- vec_cnt  out  CNT_W  accepted beats (saturating).
- ones_cnt  out  CNT_W  accepted beats with y=1 (saturating).
- conflict  out  1  sticky: same vec seen with differing y.

## Operation
- FSM: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start → RUN; sig ← all-ones, counters ← 0, conflict ← 0, table cleared.
- RUN + start → restart (same clears); a beat in that cycle is discarded.
- RUN + end_req → DONE; a beat handshaked in the same cycle is accepted first.
- end_req outside RUN ignored; start has priority over end_req.
- vec_ready = (state==RUN). Beat accepted iff vec_valid && vec_ready at the clock edge.
- MISR per beat: sig ← (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended {vec,y} (8-bit data in LSBs).
- vec_cnt += 1 and ones_cnt += y per beat; both saturate at 2^CNT_W−1 (no wrap).
- busy = RUN; done = DONE (level, held until start).
- Outputs hold their values in IDLE/DONE; no beats accepted outside RUN.

## Timing
- Reset values: vec_ready 0, busy 0, done 0, sig all-ones, vec_cnt 0, ones_cnt 0, conflict 0.
- Latency: results of a beat visible on sig/counters/conflict one cycle after the accepting edge.
- start → busy/vec_ready high next cycle; end_req → done high next cycle.
- Back-to-back beats accepted every cycle in RUN (full throughput, no bubbles).
- vec_valid must not depend combinationally on vec_ready; the source holds vec/y stable while valid && !ready.
- Reset asserted mid-session: immediate return to reset values; session lost.

## Configuration
- RESP_TABLE_EN defined: 128-entry seen bitmap plus 128-entry y bitmap indexed by vec. On a beat with seen[vec]=1 and stored y≠y, conflict sets (same cycle as the beat's other updates) and stays set until start/reset. First occurrence stores y and sets seen. Tables clear on start.
- Undefined: no tables; conflict tied to 0.

## Structure
- Package resp_pkg: state enum (IDLE, RUN, DONE), VEC_W=7, default POLY and SIG_W.
- Sub-module resp_misr: SIG_W/POLY-parameterised register with init, enable and 8-bit data input; instantiated once.

## Test plan
- Reset, then start: sig=16'hFFFF, vec_cnt=0, busy=1, vec_ready=1 one cycle later.
- Single beat vec=7'h00, y=0 → sig=16'hEFDF, vec_cnt=1, ones_cnt=0. Alternatively vec=7'h03, y=1 → sig=16'hEFD8, ones_cnt=1.
- 300 consecutive beats with y=1 → vec_cnt=ones_cnt=255 (saturated); end_req → done=1, vec_ready=0; further valid beats ignored, values unchanged.
- end_req in the same cycle as a beat → beat counted (vec_cnt increments), done next cycle. start in the same cycle as a beat → beat discarded, sig=16'hFFFF.
- With RESP_TABLE_EN: vec=7'h18, y=0, then vec=7'h18, y=1 → conflict=1 and held. Repeating vec=7'h18, y=0 twice → conflict stays 0. start clears conflict.
- rst_n low mid-RUN after 5 beats → all outputs return to reset values asynchronously; start then resumes normally.
